// File: rtl/aes_pkg.sv
// Shared AES-round definitions: default widths and the byte-wise XOR helper
// used by the AddRoundKey pipeline.
package aes_pkg;

    localparam int DATA_W_DEF = 128;
    localparam int NKEYS_DEF  = 15;

    // One byte of AddRoundKey: state byte XOR key byte.
    function automatic logic [7:0] xor_byte(input logic [7:0] a, input logic [7:0] b);
        return a ^ b;
    endfunction

endpackage

// File: rtl/ark_fifo.sv
// Show-ahead synchronous FIFO holding AddRoundKey results with their round
// index. The head entry is presented combinationally so a word written on
// one edge is visible right after it. Pointers wrap modulo DEPTH.
module ark_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic [CNT_W-1:0] o_count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Storage array; contents need no reset because count gates validity.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointer and occupancy tracking; simultaneous push/pop keeps count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (i_pop && !i_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/ark_pipe.sv
// AddRoundKey pipeline: XORs each accepted state word with a stored round
// key and buffers the result (plus its round index) in a small FIFO.
// Optional macro ARK_KEY_FWD_EN: a key written on the same edge as an
// accept to that slot is forwarded into the XOR instead of the old key.
module ark_pipe
    import aes_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int NKEYS  = NKEYS_DEF,
    parameter  int DEPTH  = 2,
    localparam int KIDX_W = (NKEYS > 1) ? $clog2(NKEYS) : 1,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_we,
    input  logic [KIDX_W-1:0] key_waddr,
    input  logic [DATA_W-1:0] key_wdata,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [KIDX_W-1:0] in_round,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [KIDX_W-1:0] out_round,
    output logic [CNT_W-1:0]  count,
    output logic              err
);
    localparam int NBYTES = DATA_W / 8;

    logic [DATA_W-1:0]        r_keys [NKEYS];
    logic                     r_err;
    logic [DATA_W-1:0]        w_key;
    logic [DATA_W-1:0]        w_result;
    logic                     w_round_ok;
    logic                     w_push;
    logic                     w_pop;
    logic [CNT_W-1:0]         w_count;
    logic [DATA_W+KIDX_W-1:0] w_rdata;

    genvar gi;

    // Round-key registers, one per slot; writes to nonexistent slots are dropped.
    generate
        for (gi = 0; gi < NKEYS; gi++) begin : g_key
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_keys[gi] <= '0;
                end else if (key_we && (key_waddr == KIDX_W'(gi))) begin
                    r_keys[gi] <= key_wdata;
                end
            end
        end
    endgenerate

    assign w_round_ok = (int'(in_round) < NKEYS);

    // Key select: out-of-range rounds see an all-zero key.
    always_comb begin
        w_key = '0;
        if (w_round_ok) begin
            w_key = r_keys[in_round];
`ifdef ARK_KEY_FWD_EN
            if (key_we && (key_waddr == in_round)) begin
                w_key = key_wdata;
            end
`endif
        end
    end

    // Byte-wise AddRoundKey.
    generate
        for (gi = 0; gi < NBYTES; gi++) begin : g_xor
            assign w_result[gi*8 +: 8] = xor_byte(in_data[gi*8 +: 8], w_key[gi*8 +: 8]);
        end
    endgenerate

    assign out_valid = (w_count != '0);
    assign w_pop     = out_valid && out_ready;
    // Held low during reset; a pop frees a slot for a same-cycle push.
    assign in_ready  = rst && ((w_count < CNT_W'(DEPTH)) || w_pop);
    assign w_push    = in_valid && in_ready;

    // Sticky flag for any accepted word with an out-of-range round index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (w_push && !w_round_ok) begin
            r_err <= 1'b1;
        end
    end

    ark_fifo #(
        .WIDTH(DATA_W + KIDX_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst),
        .i_push (w_push),
        .i_pop  (w_pop),
        .i_wdata({in_round, w_result}),
        .o_rdata(w_rdata),
        .o_count(w_count)
    );

    assign out_data  = w_rdata[DATA_W-1:0];
    assign out_round = w_rdata[DATA_W +: KIDX_W];
    assign count     = w_count;
    assign err       = r_err;

endmodule

// File: tb/tb_ark_pipe.sv
// Directed testbench for ark_pipe with default parameters (128b, 15 keys, depth 2).
module tb_ark_pipe;

    logic         clk;
    logic         rst;
    logic         key_we;
    logic [3:0]   key_waddr;
    logic [127:0] key_wdata;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [3:0]   in_round;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [3:0]   out_round;
    logic [1:0]   count;
    logic         err;

    int total;
    int bad;

    ark_pipe dut (
        .clk      (clk),
        .rst      (rst),
        .key_we   (key_we),
        .key_waddr(key_waddr),
        .key_wdata(key_wdata),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_round (in_round),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_round(out_round),
        .count    (count),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] word(input int i);
        return {4{32'hA500_0000 + i}};
    endfunction

    logic [127:0] d;

    initial begin
        total = 0; bad = 0;
        rst = 1'b0; key_we = 1'b0; key_waddr = '0; key_wdata = '0;
        in_valid = 1'b0; in_data = '0; in_round = '0; out_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_in_ready", {127'b0, in_ready}, 128'd0);
        chk("rst_out_valid", {127'b0, out_valid}, 128'd0);
        chk("rst_count", {126'b0, count}, 128'd0);
        chk("rst_err", {127'b0, err}, 128'd0);
        rst = 1'b1;
        tick();
        chk("post_rst_in_ready", {127'b0, in_ready}, 128'd1);

        // Known-answer AddRoundKey, round 0
        key_we = 1'b1; key_waddr = 4'd0; key_wdata = 128'h000102030405060708090a0b0c0d0e0f;
        tick();
        key_we = 1'b0;
        in_valid = 1'b1; in_round = 4'd0; in_data = 128'h00112233445566778899aabbccddeeff;
        tick();
        in_valid = 1'b0;
        chk("kat_valid", {127'b0, out_valid}, 128'd1);
        chk("kat_data", out_data, 128'h00102030405060708090a0b0c0d0e0f0);
        chk("kat_round", {124'b0, out_round}, 128'd0);
        out_ready = 1'b1;
        tick();
        chk("kat_drained", {127'b0, out_valid}, 128'd0);

        // Backpressure: three words into a two-entry buffer (key[1] is zero)
        out_ready = 1'b0; in_round = 4'd1; in_valid = 1'b1;
        in_data = word(1); tick();
        in_data = word(2); tick();
        in_data = word(3);
        chk("bp_count_full", {126'b0, count}, 128'd2);
        chk("bp_in_ready_low", {127'b0, in_ready}, 128'd0);
        tick();
        chk("bp_count_held", {126'b0, count}, 128'd2);
        chk("bp_head_stable", out_data, word(1));
        chk("bp_round", {124'b0, out_round}, 128'd1);
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_on_pop", {127'b0, in_ready}, 128'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_second", out_data, word(2));
        chk("bp_count_swap", {126'b0, count}, 128'd2);
        tick();
        chk("bp_third", out_data, word(3));
        tick();
        chk("bp_empty", {126'b0, count}, 128'd0);

        // Full buffer streaming: push and pop together for five cycles
        out_ready = 1'b0; in_round = 4'd2; in_valid = 1'b1;
        in_data = word(10); tick();
        in_data = word(11); tick();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = word(12 + i);
            chk($sformatf("stream_out%0d", i), out_data, word(10 + i));
            tick();
            chk($sformatf("stream_cnt%0d", i), {126'b0, count}, 128'd2);
        end
        in_valid = 1'b0;
        chk("stream_tail0", out_data, word(15));
        tick();
        chk("stream_tail1", out_data, word(16));
        tick();
        chk("stream_empty", {126'b0, count}, 128'd0);

        // Same-edge key write to slot 3 and accept on round 3
        d = 128'h0123456789abcdef_fedcba9876543210;
        key_we = 1'b1; key_waddr = 4'd3; key_wdata = {128{1'b1}};
        in_valid = 1'b1; in_round = 4'd3; in_data = d;
        tick();
        key_we = 1'b0;
`ifdef ARK_KEY_FWD_EN
        chk("same_edge_key", out_data, ~d);
`else
        chk("same_edge_key", out_data, d);
`endif
        // Next word sees the newly written key in either build
        tick();
        in_valid = 1'b0;
        chk("new_key_used", out_data, ~d);
        tick();
        chk("key3_drained", {126'b0, count}, 128'd0);
        chk("err_still_clear", {127'b0, err}, 128'd0);

        // Out-of-range round index
        in_valid = 1'b1; in_round = 4'd15; in_data = word(77);
        tick();
        in_valid = 1'b0;
        chk("oor_data", out_data, word(77));
        chk("oor_round", {124'b0, out_round}, 128'd15);
        chk("oor_err", {127'b0, err}, 128'd1);
        tick(); tick(); tick();
        chk("oor_err_sticky", {127'b0, err}, 128'd1);

        // Reset mid-stream with two words buffered
        out_ready = 1'b0; in_round = 4'd0; in_valid = 1'b1;
        in_data = word(40); tick();
        in_data = word(41); tick();
        in_valid = 1'b0;
        chk("pre_rst_count", {126'b0, count}, 128'd2);
        #2;
        rst = 1'b0;
        #1;
        chk("async_out_valid", {127'b0, out_valid}, 128'd0);
        chk("async_count", {126'b0, count}, 128'd0);
        chk("async_err", {127'b0, err}, 128'd0);
        chk("async_in_ready", {127'b0, in_ready}, 128'd0);
        tick();
        rst = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("rel_out_valid", {127'b0, out_valid}, 128'd0);
        chk("rel_in_ready", {127'b0, in_ready}, 128'd1);
        // Key 0 was cleared by reset, so the word passes through unchanged
        in_valid = 1'b1; in_round = 4'd0; in_data = word(50);
        tick();
        in_valid = 1'b0;
        chk("rel_key_cleared", out_data, word(50));
        chk("rel_count", {126'b0, count}, 128'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
